// File: rtl/dht11_meas_sched.sv
// dht11_meas_sched
//   Measurement scheduler for the DHT11 interface. Launches the start-signal
//   unit, enables the byte receiver for one frame, verifies the checksum,
//   retries failed attempts and enforces the minimum gap between attempts.
//
// Ports
//   clk, rst            system clock (1 MHz tick base), async active-high reset
//   enable              level: continuous polling request
//   trigger             pulse: single-shot measurement request
//   start_go            pulse: launch the start-signal unit
//   start_ack           pulse: sensor response phase completed
//   rx_en               receiver enable for the whole frame reception
//   rx_valid, rx_byte   received byte strobe and data (frame order)
//   hum_int .. temp_dec last good measurement
//   data_valid          pulse: result outputs updated
//   meas_fail           pulse: all attempts of a measurement exhausted
//   err_timeout,
//   err_checksum        sticky cause of the last failed measurement
//   busy                measurement in progress, including pending retries
//   retry_cnt           retries used in the current measurement
module dht11_meas_sched #(
    parameter int POLL_CYCLES    = 2_000_000,
    parameter int TIMEOUT_CYCLES = 10_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           trigger,
    output logic                           start_go,
    input  logic                           start_ack,
    output logic                           rx_en,
    input  logic                           rx_valid,
    input  logic [7:0]                     rx_byte,
    output logic [7:0]                     hum_int,
    output logic [7:0]                     hum_dec,
    output logic [7:0]                     temp_int,
    output logic [7:0]                     temp_dec,
    output logic                           data_valid,
    output logic                           meas_fail,
    output logic                           err_timeout,
    output logic                           err_checksum,
    output logic                           busy,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int GW = $clog2(POLL_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RESP,
        RECV,
        CHECK
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [GW-1:0]   gap_cnt;
    logic [WW-1:0]   wd_cnt;
    logic [2:0]      idx;
    logic [7:0]      frame [0:4];
    logic            trig_pend;
    logic            retry_pend;

    logic            gap_done;
    logic            wd_zero;
    logic [7:0]      sum;
    logic            fail;
    logic            fail_to;
    logic            success;
    logic            attempt_end;
    logic            enter_start;
    logic            retry_last;
    logic            retry_pend_next;

    assign gap_done    = (gap_cnt == '0);
    assign wd_zero     = (wd_cnt == '0);
    assign sum         = frame[0] + frame[1] + frame[2] + frame[3];
    assign attempt_end = fail | success;
    assign retry_last  = (retry_cnt == RW'(MAX_RETRY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        fail            = 1'b0;
        fail_to         = 1'b0;
        success         = 1'b0;
        enter_start     = 1'b0;
        retry_pend_next = retry_pend;
        case (state)
            IDLE: begin
                if (gap_done && (retry_pend || enable || trig_pend)) begin
                    state_next  = START;
                    enter_start = 1'b1;
                end
            end
            START: begin
                state_next = RESP;
            end
            RESP: begin
                if (start_ack) begin
                    state_next = RECV;
                end else if (wd_zero) begin
                    fail       = 1'b1;
                    fail_to    = 1'b1;
                    state_next = IDLE;
                end
            end
            RECV: begin
                // a final byte arriving in the expiry cycle still completes the frame
                if (rx_valid && (idx == 3'd4)) begin
                    state_next = CHECK;
                end else if (wd_zero) begin
                    fail       = 1'b1;
                    fail_to    = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                if (sum == frame[4]) begin
                    success = 1'b1;
                end else begin
                    fail = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (enter_start) begin
            retry_pend_next = 1'b0;
        end else if (fail) begin
            retry_pend_next = !retry_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_go     <= 1'b0;
            rx_en        <= 1'b0;
            busy         <= 1'b0;
            data_valid   <= 1'b0;
            meas_fail    <= 1'b0;
            err_timeout  <= 1'b0;
            err_checksum <= 1'b0;
            retry_cnt    <= '0;
            hum_int      <= '0;
            hum_dec      <= '0;
            temp_int     <= '0;
            temp_dec     <= '0;
            gap_cnt      <= GW'(POLL_CYCLES);
            wd_cnt       <= '0;
            idx          <= '0;
            trig_pend    <= 1'b0;
            retry_pend   <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) begin
                frame[i] <= '0;
            end
        end else begin
            // registered outputs are driven from the next-state decode so they
            // line up with the state they describe
            start_go   <= (state_next == START);
            rx_en      <= (state_next == RECV);
            busy       <= (state_next != IDLE) || retry_pend_next;
            retry_pend <= retry_pend_next;
            data_valid <= 1'b0;
            meas_fail  <= 1'b0;

            if (enter_start) begin
                trig_pend <= 1'b0;
            end else if (trigger) begin
                trig_pend <= 1'b1;
            end

            if (attempt_end) begin
                gap_cnt <= GW'(POLL_CYCLES);
            end else if (!gap_done) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            if ((state == START) || ((state == RESP) && start_ack)) begin
                wd_cnt <= WW'(TIMEOUT_CYCLES);
            end else if (((state == RESP) || (state == RECV)) && !wd_zero) begin
                wd_cnt <= wd_cnt - WW'(1);
            end

            if ((state == RESP) && start_ack) begin
                idx <= '0;
            end else if ((state == RECV) && rx_valid) begin
                frame[idx] <= rx_byte;
                idx        <= idx + 3'd1;
            end

            if (success) begin
                hum_int      <= frame[0];
                hum_dec      <= frame[1];
                temp_int     <= frame[2];
                temp_dec     <= frame[3];
                data_valid   <= 1'b1;
                err_timeout  <= 1'b0;
                err_checksum <= 1'b0;
                retry_cnt    <= '0;
            end else if (fail) begin
                if (!retry_last) begin
                    retry_cnt <= retry_cnt + RW'(1);
                end else begin
                    meas_fail    <= 1'b1;
                    err_timeout  <= fail_to;
                    err_checksum <= !fail_to;
                    retry_cnt    <= '0;
                end
            end
        end
    end

endmodule

// File: doc/dht11_meas_sched.md
# dht11_meas_sched

Measurement scheduler for the DHT11 sensor interface. It sequences the start-signal unit and the bit/byte receiver, and enforces the sensor's minimum spacing between measurements. It also verifies the checksum, retries failed frames, and presents registered humidity/temperature results with a one-cycle valid strobe. It sits between the sensor-facing units and the application logic.

## Interface
- POLL_CYCLES, 2_000_000: minimum idle cycles between measurement attempts; also the power-up wait (2 s at 1 MHz).
- TIMEOUT_CYCLES, 10_000: per-phase watchdog for response and frame reception, in cycles.
- MAX_RETRY, 3: extra attempts after a failed attempt before the measurement is declared failed.

- clk  in  1  system clock (1 MHz tick base)
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  continuous polling request (level)
- trigger  in  1  single-shot measurement request (1-cycle pulse)
- start_go  out  1  1-cycle pulse launching the start-signal unit
- start_ack  in  1  1-cycle pulse: sensor response phase completed
- rx_en  out  1  receiver enable, high for the whole frame reception
- rx_valid  in  1  1-cycle pulse: rx_byte holds a received byte
- rx_byte  in  8  received byte, MSB-first order of the frame
- hum_int, hum_dec, temp_int, temp_dec  out  8 each  last good measurement
- data_valid  out  1  1-cycle pulse when outputs are updated
- meas_fail  out  1  1-cycle pulse when all attempts are exhausted
- err_timeout, err_checksum  out  1 each  sticky cause of the last failed measurement
- busy  out  1  measurement in progress, including pending retries
- retry_cnt  out  $clog2(MAX_RETRY+1)  retries used in the current measurement

## Operation
- States: IDLE, START, RESP, RECV, CHECK.
- The gap counter is loaded with POLL_CYCLES on reset and whenever an attempt ends (any outcome), then counts down to 0. gap_done is high when the counter is 0.
- trigger is latched into trig_pend, including while busy. It is cleared on entering START.
- IDLE: if gap_done and (retry_pend or enable or trig_pend), go to START. Otherwise stay.
- START: assert start_go for one cycle, load the watchdog with TIMEOUT_CYCLES, go to RESP.
- RESP: on start_ack, go to RECV, set rx_en=1, byte index=0, reload the watchdog. On watchdog=0, the attempt fails (timeout).
- RECV: each rx_valid stores rx_byte at the current index and increments the index. The 5th byte moves to CHECK with rx_en=0. On watchdog=0 without a 5th byte, the attempt fails (timeout). rx_valid in the expiry cycle wins over the timeout.
- CHECK: (b0+b1+b2+b3) mod 256 compared against b4.
  - Equal: load outputs (b0=hum_int, b1=hum_dec, b2=temp_int, b3=temp_dec), pulse data_valid, clear both err flags and retry_cnt. Go to IDLE.
  - Not equal: the attempt fails (checksum).
- Attempt failure with retry_cnt < MAX_RETRY: increment retry_cnt, set retry_pend, go to IDLE.
- Attempt failure with retry_cnt = MAX_RETRY: pulse meas_fail, set the matching err flag and clear the other, clear retry_cnt and retry_pend, go to IDLE. Data outputs keep their previous values.
- retry_pend is cleared on entering START.
- busy = state != IDLE or retry_pend.
- Deasserting enable mid-measurement does not abort: the current measurement, including retries, completes.
- start_ack outside RESP and rx_valid outside RECV are ignored.

## Timing
- Reset values: start_go 0, rx_en 0, all data outputs 0x00, data_valid 0, meas_fail 0, err flags 0, busy 0, retry_cnt 0. State is IDLE, gap counter = POLL_CYCLES, trig_pend 0, retry_pend 0.
- All outputs are registered.
- start_go is high in the cycle the FSM occupies START, one cycle after the IDLE decision.
- 5th rx_valid at cycle N: rx_en low at N+1 (CHECK), data_valid and new outputs at N+2.
- Minimum spacing from attempt end to the next start_go is POLL_CYCLES+1 cycles, for retries as well.
- Reset mid-operation: immediate return to reset values. The first start_go comes no earlier than POLL_CYCLES cycles after rst release.

## Test plan
Bench uses POLL_CYCLES=100, TIMEOUT_CYCLES=50, MAX_RETRY=2.

- Nominal: enable=1, start_ack 5 cycles after start_go, bytes 0x37,0x00,0x19,0x00,0x50 -> data_valid pulse, hum_int=0x37, temp_int=0x19, errors 0, next start_go ≥101 cycles later.
- Checksum fail: last byte 0x51 on every attempt -> 3 start_go total, retry_cnt 1 then 2, then meas_fail pulse, err_checksum=1, outputs unchanged.
- Timeout: start_ack never arrives -> 3 start_go at ≥101-cycle spacing, meas_fail, err_timeout=1, err_checksum=0.
- Single shot: enable=0, trigger during power-up gap -> exactly one start_go at gap expiry. A second trigger while busy -> exactly one further measurement.
- Reset mid-RECV after 2 bytes -> rx_en=0 and outputs 0x00 immediately, no start_go for 100 cycles after release.
- Recovery: one timeout attempt, then a good frame -> data_valid, retry_cnt=0, both err flags cleared, no meas_fail.
